// File: rtl/gf163_digit_feeder_if.sv
// Operand handshake and digit-stream bundle between the operand source,
// the digit feeder and the first PE of the systolic array.
interface gf163_digit_feeder_if #(
  parameter int M = 163,
  parameter int D = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic [M-1:0] g;
  logic [D-1:0] a_out;
  logic [D-1:0] b_out;
  logic [D-1:0] g_out;
  logic         ctr;
  logic         busy;

  modport master (
    output in_valid, a, b, g,
    input  in_ready, a_out, b_out, g_out, ctr, busy
  );

  modport slave (
    input  in_valid, a, b, g,
    output in_ready, a_out, b_out, g_out, ctr, busy
  );
endinterface

// File: rtl/gf163_digit_feeder.sv
// Captures one zero-extended GF(2^163) operand set and streams it MSD-first
// as NDIG digits into the systolic array, framing digit 0 with ctr.
//   state  | meaning
//   IDLE   | no stream; outputs zero, ready for an operand set
//   STREAM | driving digit k of the captured set; ready only on the last digit
module gf163_digit_feeder #(
  parameter int M    = 163,
  parameter int D    = 8,
  parameter int NDIG = 21
) (
  input  logic                  clk,
  input  logic                  rstn,
  gf163_digit_feeder_if.slave   bus
);
  localparam int W  = NDIG * D;
  localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [W-1:0]  sh_a;
  logic [W-1:0]  sh_b;
  logic [W-1:0]  sh_g;

  logic          accept;
  logic [W-1:0]  pad_a;
  logic [W-1:0]  pad_b;
  logic [W-1:0]  pad_g;

  assign accept = bus.in_valid & bus.in_ready;
  assign pad_a  = {{(W-M){1'b0}}, bus.a};
  assign pad_b  = {{(W-M){1'b0}}, bus.b};
  assign pad_g  = {{(W-M){1'b0}}, bus.g};

  // Digit 0 goes straight to the outputs on accept; the shift registers hold the rest.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      k            <= '0;
      sh_a         <= '0;
      sh_b         <= '0;
      sh_g         <= '0;
      bus.a_out    <= '0;
      bus.b_out    <= '0;
      bus.g_out    <= '0;
      bus.ctr      <= 1'b0;
      bus.busy     <= 1'b0;
      bus.in_ready <= 1'b1;
    end else if (accept) begin
      state        <= STREAM;
      k            <= '0;
      sh_a         <= pad_a << D;
      sh_b         <= pad_b << D;
      sh_g         <= pad_g << D;
      bus.a_out    <= pad_a[W-1 -: D];
      bus.b_out    <= pad_b[W-1 -: D];
      bus.g_out    <= pad_g[W-1 -: D];
      bus.ctr      <= 1'b1;
      bus.busy     <= 1'b1;
      bus.in_ready <= (K_LAST == '0);
    end else if (state == STREAM && k != K_LAST) begin
      k            <= k + KW'(1);
      sh_a         <= sh_a << D;
      sh_b         <= sh_b << D;
      sh_g         <= sh_g << D;
      bus.a_out    <= sh_a[W-1 -: D];
      bus.b_out    <= sh_b[W-1 -: D];
      bus.g_out    <= sh_g[W-1 -: D];
      bus.ctr      <= 1'b0;
      bus.busy     <= 1'b1;
      bus.in_ready <= ((k + KW'(1)) == K_LAST);
    end else begin
      state        <= IDLE;
      k            <= '0;
      bus.a_out    <= '0;
      bus.b_out    <= '0;
      bus.g_out    <= '0;
      bus.ctr      <= 1'b0;
      bus.busy     <= 1'b0;
      bus.in_ready <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gf163_digit_feeder.sv
// Self-checking bench for gf163_digit_feeder: queue-based digit scoreboard,
// a table of hand-computed operand vectors and multi-cycle corner sequences.
module tb_gf163_digit_feeder;
  localparam int M    = 163;
  localparam int D    = 8;
  localparam int NDIG = 21;
  localparam int W    = NDIG * D;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  gf163_digit_feeder_if #(.M(M), .D(D)) bus ();

  gf163_digit_feeder #(.M(M), .D(D), .NDIG(NDIG)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic       ctr;
    logic       last;
  } dig_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] g;
  } ops_t;

  typedef struct {
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [M-1:0] g;
    logic [7:0]   d0a, d0b, d0g;
    logic [7:0]   d20a, d20b, d20g;
  } vec_t;

  dig_t exp_q[$];
  ops_t ops_q[$];

  int total     = 0;
  int bad       = 0;
  bit m_busy    = 1'b0;
  int m_k       = 0;
  bit m_ready   = 1'b1;
  int acc_count = 0;
  int ctr_count = 0;
  bit mon_en    = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [M-1:0] rand_op();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[M-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 100) begin
      tick();
      n++;
    end
    check("idle_timeout", m_busy, 1'b0);
  endtask

  // Reference model: tracks readiness and pushes the expected digit stream on each accept.
  initial begin
    ops_t o;
    dig_t e;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        m_busy  = 1'b0;
        m_k     = 0;
        m_ready = 1'b1;
        exp_q.delete();
        ops_q.delete();
      end else begin
        if (bus.in_valid && m_ready) begin
          o.a = {{(W-M){1'b0}}, bus.a};
          o.b = {{(W-M){1'b0}}, bus.b};
          o.g = {{(W-M){1'b0}}, bus.g};
          for (int j = 0; j < NDIG; j++) begin
            e.a    = o.a[W-1-8*j -: 8];
            e.b    = o.b[W-1-8*j -: 8];
            e.g    = o.g[W-1-8*j -: 8];
            e.ctr  = (j == 0);
            e.last = (j == NDIG-1);
            exp_q.push_back(e);
          end
          ops_q.push_back(o);
          m_busy = 1'b1;
          m_k    = 0;
          acc_count++;
        end else if (m_busy) begin
          if (m_k == NDIG-1) m_busy = 1'b0;
          else m_k++;
        end
        m_ready = !m_busy || (m_k == NDIG-1);
      end
    end
  end

  // Monitor: compares every cycle against the model and reassembles each stream.
  initial begin
    dig_t e;
    ops_t o;
    logic [W-1:0] asm_a, asm_b, asm_g;
    asm_a = '0; asm_b = '0; asm_g = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("busy", bus.busy, m_busy);
        check("in_ready", bus.in_ready, m_ready);
        if (m_busy) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: actual=busy required=expected digit");
          end else begin
            e = exp_q.pop_front();
            check("a_digit", bus.a_out, e.a);
            check("b_digit", bus.b_out, e.b);
            check("g_digit", bus.g_out, e.g);
            check("ctr", bus.ctr, e.ctr);
            asm_a = {asm_a[W-9:0], bus.a_out};
            asm_b = {asm_b[W-9:0], bus.b_out};
            asm_g = {asm_g[W-9:0], bus.g_out};
            if (e.last && ops_q.size() > 0) begin
              o = ops_q.pop_front();
              check("stream_a", asm_a, o.a);
              check("stream_b", asm_b, o.b);
              check("stream_g", asm_g, o.g);
            end
          end
        end else begin
          check("idle_a_out", bus.a_out, '0);
          check("idle_b_out", bus.b_out, '0);
          check("idle_g_out", bus.g_out, '0);
          check("idle_ctr", bus.ctr, 1'b0);
        end
        if (bus.ctr === 1'b1) ctr_count++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[4];
    logic [W-1:0] p;
    logic [M-1:0] op;
    int a0, n, gap;
    bit exp_rdy, exp_ctr;

    vt[0].a = 163'd1;          vt[0].b = 163'd1 << 162;   vt[0].g = 163'hC9;
    vt[0].d0a = 8'h00; vt[0].d0b = 8'h04; vt[0].d0g = 8'h00;
    vt[0].d20a = 8'h01; vt[0].d20b = 8'h00; vt[0].d20g = 8'hC9;
    vt[1].a = {M{1'b1}};       vt[1].b = 163'hAB << 155;  vt[1].g = 163'h5A;
    vt[1].d0a = 8'h07; vt[1].d0b = 8'h05; vt[1].d0g = 8'h00;
    vt[1].d20a = 8'hFF; vt[1].d20b = 8'h00; vt[1].d20g = 8'h5A;
    vt[2].a = 163'h123;        vt[2].b = 163'd1 << 159;   vt[2].g = {M{1'b1}};
    vt[2].d0a = 8'h00; vt[2].d0b = 8'h00; vt[2].d0g = 8'h07;
    vt[2].d20a = 8'h23; vt[2].d20b = 8'h00; vt[2].d20g = 8'hFF;
    vt[3].a = 163'h5 << 160;   vt[3].b = 163'hFF << 8;    vt[3].g = 163'h80;
    vt[3].d0a = 8'h05; vt[3].d0b = 8'h00; vt[3].d0g = 8'h00;
    vt[3].d20a = 8'h00; vt[3].d20b = 8'h00; vt[3].d20g = 8'h80;

    // Reset held with in_valid asserted: nothing may start.
    bus.in_valid = 1'b1;
    bus.a = rand_op(); bus.b = rand_op(); bus.g = rand_op();
    rstn = 1'b0;
    tick();
    mon_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_ctr", bus.ctr, 1'b0);
      check("rst_a_out", bus.a_out, '0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    rstn = 1'b1;
    tick();

    // Table vectors with hand-computed first and last digits.
    for (int i = 0; i < 4; i++) begin
      bus.a = vt[i].a; bus.b = vt[i].b; bus.g = vt[i].g;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.a = rand_op(); bus.b = rand_op(); bus.g = rand_op();
      @(negedge clk);
      check("tbl_d0_a", bus.a_out, vt[i].d0a);
      check("tbl_d0_b", bus.b_out, vt[i].d0b);
      check("tbl_d0_g", bus.g_out, vt[i].d0g);
      check("tbl_d0_ctr", bus.ctr, 1'b1);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("tbl_d20_a", bus.a_out, vt[i].d20a);
      check("tbl_d20_b", bus.b_out, vt[i].d20b);
      check("tbl_d20_g", bus.g_out, vt[i].d20g);
      check("tbl_d20_ctr", bus.ctr, 1'b0);
      check("tbl_d20_busy", bus.busy, 1'b1);
      @(negedge clk);
      check("tbl_end_busy", bus.busy, 1'b0);
      check("tbl_end_a", bus.a_out, '0);
      tick();
    end

    // in_valid pulse at digit 5 is ignored.
    bus.a = rand_op(); bus.b = rand_op(); bus.g = rand_op();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    bus.a = rand_op(); bus.b = rand_op(); bus.g = rand_op();
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("busy_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_idle();
    tick();

    // Back-to-back: three sets with in_valid held high.
    bus.a = rand_op(); bus.b = rand_op(); bus.g = rand_op();
    bus.in_valid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      exp_rdy = (c == 0) || (c == 21) || (c == 42) || (c == 63);
      exp_ctr = (c == 1) || (c == 22) || (c == 43);
      @(negedge clk);
      check("b2b_in_ready", bus.in_ready, exp_rdy);
      check("b2b_ctr", bus.ctr, exp_ctr);
      check("b2b_busy", bus.busy, c != 0);
      @(posedge clk);
      #1;
      if (c == 0 || c == 21) begin
        bus.a = rand_op(); bus.b = rand_op(); bus.g = rand_op();
      end
      if (c == 42) bus.in_valid = 1'b0;
    end
    wait_idle();
    tick();

    // Reset at digit 10, then a fresh accept.
    bus.a = rand_op(); bus.b = rand_op(); bus.g = rand_op();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    rstn = 1'b0;
    tick();
    @(negedge clk);
    check("mid_rst_a", bus.a_out, '0);
    check("mid_rst_b", bus.b_out, '0);
    check("mid_rst_g", bus.g_out, '0);
    check("mid_rst_ctr", bus.ctr, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    op = rand_op();
    bus.a = op; bus.b = rand_op(); bus.g = rand_op();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    p = {{(W-M){1'b0}}, op};
    @(negedge clk);
    check("restart_ctr", bus.ctr, 1'b1);
    check("restart_a_d0", bus.a_out, p[W-1 -: 8]);
    wait_idle();
    tick();

    // Random regression with random gaps (gap 0 exercises back-to-back).
    for (int i = 0; i < 1000; i++) begin
      bus.a = rand_op(); bus.b = rand_op(); bus.g = rand_op();
      bus.in_valid = 1'b1;
      a0 = acc_count;
      n = 0;
      while (acc_count == a0 && n < 40) begin
        tick();
        n++;
      end
      check("rand_accept_timeout", acc_count, a0 + 1);
      bus.in_valid = 1'b0;
      bus.a = rand_op(); bus.b = rand_op(); bus.g = rand_op();
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
    end
    wait_idle();
    tick();

    check("ctr_per_accept", ctr_count, acc_count);
    check("queue_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
